// File: rtl/aes_axi_pkg.sv
// Shared definitions for the AXI4 burst master that drives the AES256 core's
// AXI4 slave: burst/size encodings, response codes, the master FSM state
// type and a response classification helper.
package aes_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RADDR = 3'd4,
    S_RDATA = 3'd5
  } state_e;

  // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/aes_axi4_burst_master.sv
// AXI4 full-protocol burst master.
// Accepts one command at a time (write/read, start address, beats-1) and runs
// an INCR burst of 32-bit beats: AW -> W -> B for writes, AR -> R for reads.
// Write data is streamed in on wr_valid/wr_ready/wr_data, read data is
// streamed out on rd_valid/rd_ready/rd_data/rd_last. A one-cycle done pulse,
// with done_err, reports completion in the first IDLE cycle after the burst.
//
// Ports:
//   m00_axi_aclk / m00_axi_areset  clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len   command port
//   wr_valid/wr_ready, wr_data                          write-data stream in
//   rd_valid/rd_ready, rd_data, rd_last                 read-data stream out
//   done, done_err                                      completion status
//   m00_axi_aw*, m00_axi_w*, m00_axi_b*, m00_axi_ar*, m00_axi_r*   AXI4 master
//   dbg_state_o                                         current FSM state
//
// Handshake rule for every valid/ready pair: a transfer happens on the rising
// edge where both are high; a source never drops valid or changes payload
// before that edge, and ready may depend combinationally on valid.
module aes_axi4_burst_master
  import aes_axi_pkg::*;
#(
  parameter int              ADDR_W = 6,
  parameter int              DATA_W = 32,
  parameter int              ID_W   = 2,
  parameter logic [ID_W-1:0] ID_VAL = {ID_W{1'b1}}
) (
  input  logic                  m00_axi_aclk,
  input  logic                  m00_axi_areset,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  // write-data stream
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  // read-data stream
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  // completion
  output logic                  done,
  output logic                  done_err,
  // AW channel
  output logic [ADDR_W-1:0]     m00_axi_awaddr,
  output logic [7:0]            m00_axi_awlen,
  output logic [2:0]            m00_axi_awsize,
  output logic [1:0]            m00_axi_awburst,
  output logic [ID_W-1:0]       m00_axi_awid,
  output logic                  m00_axi_awvalid,
  input  logic                  m00_axi_awready,
  // W channel
  output logic [DATA_W-1:0]     m00_axi_wdata,
  output logic [DATA_W/8-1:0]   m00_axi_wstrb,
  output logic                  m00_axi_wlast,
  output logic                  m00_axi_wvalid,
  input  logic                  m00_axi_wready,
  // B channel
  input  logic [1:0]            m00_axi_bresp,
  input  logic                  m00_axi_bvalid,
  output logic                  m00_axi_bready,
  // AR channel
  output logic [ADDR_W-1:0]     m00_axi_araddr,
  output logic [7:0]            m00_axi_arlen,
  output logic [2:0]            m00_axi_arsize,
  output logic [1:0]            m00_axi_arburst,
  output logic                  m00_axi_arvalid,
  input  logic                  m00_axi_arready,
  // R channel
  input  logic [DATA_W-1:0]     m00_axi_rdata,
  input  logic [1:0]            m00_axi_rresp,
  input  logic                  m00_axi_rlast,
  input  logic                  m00_axi_rvalid,
  output logic                  m00_axi_rready,
  // debug
  output logic [2:0]            dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              rd_err;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic (including the inline beat counter and error flag)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    rd_err     = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? S_WADDR : S_RADDR;
        end
      end

      S_WADDR: begin
        if (m00_axi_awready) state_d = S_WDATA;
      end

      S_WDATA: begin
        if (wr_valid && m00_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_WRESP;
        end
      end

      S_WRESP: begin
        if (m00_axi_bvalid) begin
          done_d     = 1'b1;
          done_err_d = resp_is_err(m00_axi_bresp);
          state_d    = S_IDLE;
        end
      end

      S_RADDR: begin
        if (m00_axi_arready) state_d = S_RDATA;
      end

      S_RDATA: begin
        if (m00_axi_rvalid && rd_ready) begin
          cnt_d  = cnt_q + 8'd1;
          rd_err = err_q | resp_is_err(m00_axi_rresp);
          if (m00_axi_rlast) begin
            // rlast must coincide with the beat numbered len.
            if (cnt_q != len_q) rd_err = 1'b1;
            done_d     = 1'b1;
            done_err_d = rd_err;
            state_d    = S_IDLE;
          end else if (cnt_q == len_q) begin
            // Slave overran the requested length: flag it but keep draining
            // beats until it finally signals rlast.
            rd_err = 1'b1;
          end
          err_d = rd_err;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready       = 1'b0;
    m00_axi_awvalid = 1'b0;
    m00_axi_wvalid  = 1'b0;
    m00_axi_wlast   = 1'b0;
    wr_ready        = 1'b0;
    m00_axi_bready  = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    rd_valid        = 1'b0;
    rd_last         = 1'b0;

    case (state_q)
      S_IDLE:  cmd_ready = ~m00_axi_areset;
      S_WADDR: m00_axi_awvalid = 1'b1;
      S_WDATA: begin
        m00_axi_wvalid = wr_valid;
        wr_ready       = m00_axi_wready;
        m00_axi_wlast  = (cnt_q == len_q);
      end
      S_WRESP: m00_axi_bready = 1'b1;
      S_RADDR: m00_axi_arvalid = 1'b1;
      S_RDATA: begin
        rd_valid       = m00_axi_rvalid;
        m00_axi_rready = rd_ready;
        rd_last        = m00_axi_rlast;
      end
      default: ;
    endcase
  end

  // Address-channel payloads come from the latched command and stay stable
  // for the whole burst.
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awlen   = len_q;
  assign m00_axi_awsize  = SIZE_4B;
  assign m00_axi_awburst = BURST_INCR;
  assign m00_axi_awid    = ID_VAL;

  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arlen   = len_q;
  assign m00_axi_arsize  = SIZE_4B;
  assign m00_axi_arburst = BURST_INCR;

  assign m00_axi_wdata   = wr_data;
  assign m00_axi_wstrb   = '1;
  assign rd_data         = m00_axi_rdata;

  assign done            = done_q;
  assign done_err        = done_err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_aes_axi4_burst_master.sv
module tb_aes_axi4_burst_master;
  import aes_axi_pkg::*;

  logic        clk;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [5:0]  m00_axi_awaddr, m00_axi_araddr;
  logic [7:0]  m00_axi_awlen, m00_axi_arlen;
  logic [2:0]  m00_axi_awsize, m00_axi_arsize;
  logic [1:0]  m00_axi_awburst, m00_axi_arburst, m00_axi_awid;
  logic        m00_axi_awvalid, m00_axi_awready;
  logic [31:0] m00_axi_wdata;
  logic [3:0]  m00_axi_wstrb;
  logic        m00_axi_wlast, m00_axi_wvalid, m00_axi_wready;
  logic [1:0]  m00_axi_bresp;
  logic        m00_axi_bvalid, m00_axi_bready;
  logic        m00_axi_arvalid, m00_axi_arready;
  logic [31:0] m00_axi_rdata;
  logic [1:0]  m00_axi_rresp;
  logic        m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;
  logic [2:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wsrc_q[$];

  aes_axi4_burst_master dut (
    .m00_axi_aclk(clk), .m00_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awlen(m00_axi_awlen),
    .m00_axi_awsize(m00_axi_awsize), .m00_axi_awburst(m00_axi_awburst),
    .m00_axi_awid(m00_axi_awid), .m00_axi_awvalid(m00_axi_awvalid),
    .m00_axi_awready(m00_axi_awready),
    .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb),
    .m00_axi_wlast(m00_axi_wlast), .m00_axi_wvalid(m00_axi_wvalid),
    .m00_axi_wready(m00_axi_wready),
    .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid),
    .m00_axi_bready(m00_axi_bready),
    .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
    .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
    .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
    .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
    .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid),
    .m00_axi_rready(m00_axi_rready),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_slave();
    m00_axi_awready = 1'b0; m00_axi_wready = 1'b0;
    m00_axi_bvalid = 1'b0;  m00_axi_bresp = 2'b00;
    m00_axi_arready = 1'b0; m00_axi_rvalid = 1'b0;
    m00_axi_rdata = '0;     m00_axi_rresp = 2'b00; m00_axi_rlast = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b required 0", done); end
    end
  endtask

  // Write burst against a slave model. Expected W stream = wsrc_q in order,
  // len+1 beats, wlast only on the final one; done one cycle after B with
  // done_err = bresp is SLVERR/DECERR. Returns in the done cycle.
  task automatic do_write(input logic [5:0] addr, input logic [7:0] len, input logic [1:0] bresp,
                          input int aw_delay, input bit gappy, input bit noise, input string tag);
    int nbeats, src_i, aw_wait, w_seen, cyc, budget;
    bit aw_done, b_pending, b_hs, b_hs_prev, finished, in_w, hs, w_hold;
    logic [31:0] exp_d;
    logic exp_last;
    nbeats = int'(len) + 1; src_i = 0; aw_wait = 0; w_seen = 0; cyc = 0;
    budget = nbeats * 16 + 60;
    aw_done = 0; b_pending = 0; b_hs = 0; finished = 0; w_hold = 0;
    exp_q.delete();
    foreach (wsrc_q[i]) exp_q.push_back(wsrc_q[i]);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready: got %b required 1", tag, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (m00_axi_awvalid !== 1'b1) begin errors++; $display("FAIL %s awvalid_rise: got %b required 1", tag, m00_axi_awvalid); end
    while (!finished && cyc < budget) begin
      b_hs_prev = b_hs; b_hs = 0;
      checks++;
      if (done !== b_hs_prev) begin errors++; $display("FAIL %s done: got %b required %b", tag, done, b_hs_prev); end
      if (b_hs_prev) begin
        checks++;
        if (done_err !== bresp[1]) begin errors++; $display("FAIL %s done_err: got %b required %b", tag, done_err, bresp[1]); end
        finished = 1;
      end else begin
        if (noise) begin
          cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom_range(0, 1));
          cmd_addr = 6'($urandom_range(0, 63)); cmd_len = 8'($urandom_range(0, 255));
        end
        if (m00_axi_awvalid) begin m00_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
        else m00_axi_awready = 1'b0;
        if (src_i < nbeats) begin
          wr_valid = w_hold ? 1'b1 : (gappy ? 1'($urandom_range(0, 1)) : 1'b1);
          wr_data = wsrc_q[src_i];
        end else wr_valid = 1'b0;
        m00_axi_wready = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
        m00_axi_bvalid = b_pending;
        m00_axi_bresp = b_pending ? bresp : 2'b00;
        in_w = aw_done && (w_seen < nbeats);
        #1;
        if (m00_axi_awvalid) begin
          checks += 5;
          if (m00_axi_awaddr !== addr) begin errors++; $display("FAIL %s awaddr: got %h required %h", tag, m00_axi_awaddr, addr); end
          if (m00_axi_awlen !== len) begin errors++; $display("FAIL %s awlen: got %h required %h", tag, m00_axi_awlen, len); end
          if (m00_axi_awsize !== 3'b010) begin errors++; $display("FAIL %s awsize: got %h required 2", tag, m00_axi_awsize); end
          if (m00_axi_awburst !== 2'b01) begin errors++; $display("FAIL %s awburst: got %h required 1", tag, m00_axi_awburst); end
          if (m00_axi_awid !== 2'b11) begin errors++; $display("FAIL %s awid: got %h required 3", tag, m00_axi_awid); end
        end
        checks++;
        if (in_w) begin
          if (m00_axi_wvalid !== wr_valid || wr_ready !== m00_axi_wready) begin
            errors++; $display("FAIL %s w_passthru: got wvalid=%b wr_ready=%b required %b %b", tag, m00_axi_wvalid, wr_ready, wr_valid, m00_axi_wready);
          end
        end else if (m00_axi_wvalid !== 1'b0) begin
          errors++; $display("FAIL %s wvalid_outside_wdata: got %b required 0", tag, m00_axi_wvalid);
        end
        checks++;
        if (m00_axi_bready !== m00_axi_bvalid) begin errors++; $display("FAIL %s bready: got %b required %b", tag, m00_axi_bready, m00_axi_bvalid); end
        hs = m00_axi_wvalid && m00_axi_wready;
        if (hs) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s extra_w_beat: got beat %0d required none", tag, w_seen);
          end else begin
            exp_d = exp_q.pop_front(); exp_last = (exp_q.size() == 0);
            if (m00_axi_wdata !== exp_d) begin errors++; $display("FAIL %s wdata: got %h required %h", tag, m00_axi_wdata, exp_d); end
            checks += 2;
            if (m00_axi_wlast !== exp_last) begin errors++; $display("FAIL %s wlast: got %b required %b", tag, m00_axi_wlast, exp_last); end
            if (m00_axi_wstrb !== 4'hF) begin errors++; $display("FAIL %s wstrb: got %h required f", tag, m00_axi_wstrb); end
          end
          w_seen++; src_i++;
          if (w_seen == nbeats) b_pending = 1;
        end
        w_hold = wr_valid && !hs;
        if (m00_axi_awvalid && m00_axi_awready) aw_done = 1;
        if (m00_axi_bvalid && m00_axi_bready) begin b_hs = 1; b_pending = 0; end
        tick();
        cyc++;
      end
    end
    checks += 2;
    if (!finished) begin errors++; $display("FAIL %s timeout: got no done within %0d cycles required done", tag, budget); end
    if (w_seen != nbeats) begin errors++; $display("FAIL %s w_beats: got %0d required %0d", tag, w_seen, nbeats); end
    cmd_valid = 1'b0;
    idle_slave();
  endtask

  // Read burst: the slave model sends nbeats beats (rlast on the last), with
  // SLVERR on beat err_beat (-1 = none). Expected done_err = any error
  // response accepted, or beat count differing from len+1.
  task automatic do_read(input logic [5:0] addr, input logic [7:0] len, input int nbeats,
                         input int err_beat, input bit toggle, input string tag);
    logic [31:0] src[$];
    logic [31:0] d, exp_d;
    logic exp_err;
    int r_i, cyc, budget;
    bit ar_done, r_fin, fin_hs, fin_prev, finished, in_r, hs, r_hold;
    exp_q.delete();
    for (int i = 0; i < nbeats; i++) begin
      d = $urandom; src.push_back(d); exp_q.push_back(d);
    end
    exp_err = (err_beat >= 0 && err_beat < nbeats) || (nbeats != int'(len) + 1);
    r_i = 0; cyc = 0; budget = nbeats * 16 + 60;
    ar_done = 0; r_fin = 0; fin_hs = 0; finished = 0; r_hold = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready: got %b required 1", tag, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (m00_axi_arvalid !== 1'b1) begin errors++; $display("FAIL %s arvalid_rise: got %b required 1", tag, m00_axi_arvalid); end
    while (!finished && cyc < budget) begin
      fin_prev = fin_hs; fin_hs = 0;
      checks++;
      if (done !== fin_prev) begin errors++; $display("FAIL %s done: got %b required %b", tag, done, fin_prev); end
      if (fin_prev) begin
        checks++;
        if (done_err !== exp_err) begin errors++; $display("FAIL %s done_err: got %b required %b", tag, done_err, exp_err); end
        finished = 1;
      end else begin
        m00_axi_arready = m00_axi_arvalid ? 1'($urandom_range(0, 1)) : 1'b0;
        if (ar_done && r_i < nbeats) begin
          m00_axi_rvalid = r_hold ? 1'b1 : ($urandom_range(0, 3) != 0);
          m00_axi_rdata = src[r_i];
          m00_axi_rresp = (r_i == err_beat) ? RESP_SLVERR : RESP_OKAY;
          m00_axi_rlast = (r_i == nbeats - 1);
        end else begin
          m00_axi_rvalid = 1'b0; m00_axi_rresp = 2'b00; m00_axi_rlast = 1'b0;
        end
        rd_ready = toggle ? ~rd_ready : 1'b1;
        in_r = ar_done && !r_fin;
        #1;
        if (m00_axi_arvalid) begin
          checks += 4;
          if (m00_axi_araddr !== addr) begin errors++; $display("FAIL %s araddr: got %h required %h", tag, m00_axi_araddr, addr); end
          if (m00_axi_arlen !== len) begin errors++; $display("FAIL %s arlen: got %h required %h", tag, m00_axi_arlen, len); end
          if (m00_axi_arsize !== 3'b010) begin errors++; $display("FAIL %s arsize: got %h required 2", tag, m00_axi_arsize); end
          if (m00_axi_arburst !== 2'b01) begin errors++; $display("FAIL %s arburst: got %h required 1", tag, m00_axi_arburst); end
        end
        checks++;
        if (in_r) begin
          if (m00_axi_rready !== rd_ready || rd_valid !== m00_axi_rvalid) begin
            errors++; $display("FAIL %s r_passthru: got rready=%b rd_valid=%b required %b %b", tag, m00_axi_rready, rd_valid, rd_ready, m00_axi_rvalid);
          end
        end else if (m00_axi_rready !== 1'b0 || rd_valid !== 1'b0) begin
          errors++; $display("FAIL %s r_outside_rdata: got rready=%b rd_valid=%b required 0 0", tag, m00_axi_rready, rd_valid);
        end
        hs = m00_axi_rvalid && m00_axi_rready;
        if (hs) begin
          checks += 2;
          exp_d = exp_q.pop_front();
          if (rd_data !== exp_d) begin errors++; $display("FAIL %s rd_data: got %h required %h", tag, rd_data, exp_d); end
          if (rd_last !== m00_axi_rlast) begin errors++; $display("FAIL %s rd_last: got %b required %b", tag, rd_last, m00_axi_rlast); end
          if (m00_axi_rlast) begin fin_hs = 1; r_fin = 1; end
          r_i++;
        end
        r_hold = m00_axi_rvalid && !hs;
        if (m00_axi_arvalid && m00_axi_arready) ar_done = 1;
        tick();
        cyc++;
      end
    end
    checks += 2;
    if (!finished) begin errors++; $display("FAIL %s timeout: got no done within %0d cycles required done", tag, budget); end
    if (r_i != nbeats) begin errors++; $display("FAIL %s r_beats: got %0d required %0d", tag, r_i, nbeats); end
    cmd_valid = 1'b0;
    idle_slave();
  endtask

  task automatic fill_wsrc(input int n);
    wsrc_q.delete();
    for (int i = 0; i < n; i++) wsrc_q.push_back($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h05; cmd_len = 8'd3;
    idle_slave();
    tick(); tick();
    checks += 4;
    if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state_o, S_IDLE); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    if ({m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_valids: got %b required 00000", {m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready});
    end
    if ({done, done_err} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b required 00", {done, done_err}); end
    cmd_valid = 1'b0; areset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready: got %b required 1", cmd_ready); end
    idle(1);
  endtask

  task automatic test_write_single();
    wsrc_q.delete(); wsrc_q.push_back(32'hFFFF_FFFF);
    do_write(6'h01, 8'd0, RESP_OKAY, 2, 1'b0, 1'b0, "write_single");
    idle(2);
  endtask

  task automatic test_write_gapped();
    wsrc_q.delete();
    wsrc_q.push_back(32'hABAB_ABAB); wsrc_q.push_back(32'hCDCD_CDCD); wsrc_q.push_back(32'hEFEF_EFEF);
    do_write(6'h08, 8'd2, RESP_OKAY, 0, 1'b1, 1'b1, "write_gapped");
    idle(1);
  endtask

  task automatic test_read_toggle();
    do_read(6'h00, 8'd3, 4, -1, 1'b1, "read_toggle");
    idle(1);
  endtask

  task automatic test_errors();
    fill_wsrc(2);
    do_write(6'h0C, 8'd1, RESP_SLVERR, 1, 1'b0, 1'b0, "write_slverr");
    idle(1);
    fill_wsrc(1);
    do_write(6'h0D, 8'd0, RESP_DECERR, 0, 1'b0, 1'b0, "write_decerr");
    idle(1);
    do_read(6'h20, 8'd1, 2, 1, 1'b0, "read_slverr");
    idle(1);
  endtask

  task automatic test_early_rlast();
    do_read(6'h04, 8'd1, 1, -1, 1'b0, "read_early_rlast");
    idle(1);
    do_read(6'h04, 8'd1, 2, -1, 1'b0, "read_after_early");
    idle(1);
  endtask

  task automatic test_overrun();
    do_read(6'h30, 8'd0, 3, -1, 1'b1, "read_overrun");
    idle(1);
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h10; cmd_len = 8'd2;
    tick();
    cmd_valid = 1'b0; m00_axi_awready = 1'b1;
    #1;
    checks++;
    if (m00_axi_awvalid !== 1'b1) begin errors++; $display("FAIL mid_reset_awvalid: got %b required 1", m00_axi_awvalid); end
    tick();
    m00_axi_awready = 1'b0; wr_valid = 1'b1; wr_data = 32'h1111_1111; m00_axi_wready = 1'b1;
    #1;
    checks++;
    if (m00_axi_wvalid !== 1'b1 || m00_axi_wlast !== 1'b0) begin
      errors++; $display("FAIL mid_reset_first_beat: got wvalid=%b wlast=%b required 1 0", m00_axi_wvalid, m00_axi_wlast);
    end
    tick();
    areset = 1'b1; wr_data = 32'h2222_2222;
    tick();
    checks += 3;
    if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d required %0d", dbg_state_o, S_IDLE); end
    if ({m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready, rd_valid} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_valids: got %b required 000000", {m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready, rd_valid});
    end
    if ({done, done_err, cmd_ready} !== 3'b000) begin errors++; $display("FAIL mid_reset_done: got %b required 000", {done, done_err, cmd_ready}); end
    areset = 1'b0;
    idle_slave();
    idle(3);
    fill_wsrc(3);
    do_write(6'h10, 8'd2, RESP_OKAY, 1, 1'b0, 1'b0, "after_reset");
    idle(1);
  endtask

  task automatic test_len_max();
    fill_wsrc(256);
    do_write(6'h3F, 8'd255, RESP_OKAY, 0, 1'b1, 1'b0, "write_len255");
    idle(1);
    do_read(6'h3E, 8'd255, 256, -1, 1'b0, "read_len255");
    idle(1);
  endtask

  // Each burst starts in the done cycle of the previous one.
  task automatic test_back_to_back();
    logic [7:0] len;
    logic [1:0] br;
    int eb;
    for (int k = 0; k < 8; k++) begin
      len = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) begin
        fill_wsrc(int'(len) + 1);
        br = 2'($urandom_range(0, 3));
        do_write(6'($urandom_range(0, 63)), len, br, $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 1'b1, "b2b_write");
      end else begin
        eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, int'(len)) : -1;
        do_read(6'($urandom_range(0, 63)), len, int'(len) + 1, eb,
                1'($urandom_range(0, 1)), "b2b_read");
      end
    end
    idle(2);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    idle_slave();
    test_reset();
    test_write_single();
    test_write_gapped();
    test_read_toggle();
    test_errors();
    test_early_rlast();
    test_overrun();
    test_reset_mid_burst();
    test_len_max();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_axi4_burst_master.md
Name: aes_axi4_burst_master

Overview:
AXI4 full-protocol master that sits directly upstream of the AES256 core's AXI4 slave (myip_axi_v1_0) and drives its five channels.
- Accepts one command at a time: write or read, start address, beat count.
- Sequences AW→W→B or AR→R with INCR bursts of 32-bit beats.
- Streams write data in from, and read data out to, simple valid/ready ports.
- Used by the on-chip key/plaintext loader and by the system bench as a protocol-correct driver.

Parameters:
ADDR_W, 6, AXI address width (matches slave awaddr/araddr)
DATA_W, 32, AXI data width; strobe width DATA_W/8
ID_W, 2, AWID width
ID_VAL, 2'b11, constant driven on m00_axi_awid

Ports:
m00_axi_aclk  in  1  single clock, all logic rising-edge
m00_axi_areset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  burst start address, passed verbatim
cmd_len  in  8  beats minus 1 (AXI AxLEN semantics)
wr_valid / wr_ready  in / out  1  write-data stream handshake
wr_data  in  DATA_W  write beat payload
rd_valid / rd_ready  out / in  1  read-data stream handshake
rd_data  out  DATA_W  read beat payload
rd_last  out  1  final read beat
done  out  1  one-cycle pulse at burst completion
done_err  out  1  valid with done; 1 = SLVERR/DECERR or protocol error
m00_axi_awaddr, awlen(8), awsize(3), awburst(2), awid(ID_W), awvalid  out; awready  in
m00_axi_wdata(DATA_W), wstrb(DATA_W/8), wlast, wvalid  out; wready  in
m00_axi_bresp(2), bvalid  in; bready  out
m00_axi_araddr, arlen(8), arsize(3), arburst(2), arvalid  out; arready  in
m00_axi_rdata(DATA_W), rresp(2), rlast, rvalid  in; rready  out

Behaviour:
- Clock and reset: one clock, m00_axi_aclk. Reset m00_axi_areset is synchronous and active-high.
- Reset values (and the state one edge after reset asserts, including mid-burst):
  - state=IDLE; all *valid, bready, rready, done and done_err = 0; beat counter = 0; error flag = 0.
  - No done pulse for an aborted burst.
  - cmd_ready=0 while reset is high.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr, len and write, clear counter and error.
  - Next state is WADDR or RADDR. A*valid is registered, so it rises the cycle after acceptance.
- WADDR:
  - awvalid=1, with addr/len/awsize=3'b010/awburst=2'b01/awid=ID_VAL held stable.
  - On awready → WDATA. W never starts before AW completes.
- WDATA (combinational pass-through):
  - wvalid = wr_valid; wr_ready = wready; wdata = wr_data; wstrb = all ones.
  - wlast = (counter == len).
  - Each wvalid&&wready increments the counter. The last beat → WRESP.
- WRESP:
  - bready=1.
  - On bvalid: done=1 next cycle, done_err = bresp[1]; → IDLE.
- RADDR:
  - arvalid=1, same field rules as AW.
  - On arready → RDATA.
- RDATA:
  - rd_valid = rvalid; rready = rd_ready; rd_data = rdata; rd_last = rlast.
  - Each rvalid&&rready increments the counter and ORs rresp[1] into the error flag.
  - On a handshake with rlast → IDLE with a done pulse.
  - If rlast arrives when counter≠len, or counter passes len without rlast, set the error flag.
  - In the second case, keep accepting beats until rlast.
- done timing: asserted exactly one cycle, registered, in the first IDLE cycle. A new command can be accepted in that same cycle.
- Back-to-back commands: minimum 1 idle cycle between the last B/R handshake and the next awvalid/arvalid.
- cmd_valid while busy: ignored, no latching.
- len=0: single beat; wlast=1 on the first beat.
- len=255: 256 beats; the counter is 8 bits and never wraps before wlast.
- Address is not aligned or range-checked; the slave decodes it.

Decomposition:
- Package aes_axi_pkg:
  - BURST_INCR=2'b01, SIZE_4B=3'b010.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - State enum for the master FSM.
- Single module. No sub-module; the beat counter is inline.

Test Plan:
- Reset then cmd write addr=0x01 len=0 data=0xFFFFFFFF, slave awready after 2 cycles → awlen=0, awsize=2, awburst=1, awid=2'b11; one W beat with wlast=1, wstrb=4'hF; bresp=OKAY → done=1, done_err=0.
- Write addr=0x08 len=2, data AB.., CD.., EF.., with wr_valid gapped and wready stalled 1 cycle per beat → exactly 3 W handshakes in order; wlast only on EFEFEFEF; done once.
- Read addr=0x00 len=3 with rd_ready toggling → 4 rd beats matching rdata; rd_last on the 4th; done_err=0; rready mirrors rd_ready.
- Write with bresp=SLVERR, then read with rresp=SLVERR on beat 1 of 2 → done_err=1 both times.
- Read len=1 where the slave asserts rlast on beat 0 → done with done_err=1; return to IDLE.
- areset asserted during WDATA after 1 of 3 beats → next edge: all valids low, IDLE, no done; a following command completes normally.
